// File: rtl/vliw_regfile.sv
// rtl/vliw_regfile.sv - multi-lane VLIW integer register file
// Combinational reads with write-through bypass, highest-lane-wins writes, saturating conflict counter.
module vliw_regfile #(
  parameter int XLEN        = 64,
  parameter int NLANES      = 4,
  parameter int E_SUPPORTED = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NLANES-1:0]      we3,
  input  logic [NLANES*5-1:0]    a1,
  input  logic [NLANES*5-1:0]    a2,
  input  logic [NLANES*5-1:0]    a3,
  input  logic [NLANES*XLEN-1:0] wd3,
  output logic [NLANES*XLEN-1:0] rd1,
  output logic [NLANES*XLEN-1:0] rd2,
  input  logic                   ClearCount,
  output logic                   WriteConflict,
  output logic [7:0]             ConflictCount
);

  localparam int NREGS  = (E_SUPPORTED != 0) ? 16 : 32;
  localparam int NPORTS = 2 * NLANES;

  // The reduced register set ignores address bit 4, so 16-31 alias 0-15.
  function automatic logic [4:0] eff_addr(input logic [4:0] a);
    if (E_SUPPORTED != 0) return {1'b0, a[3:0]};
    return a;
  endfunction

  logic [4:0]      wa     [NLANES];
  logic [4:0]      ra     [NPORTS];
  logic [XLEN-1:0] rdata  [NPORTS];
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];
  logic [7:0]      conflict_count_q;
  logic [7:0]      conflict_count_d;
  logic            write_conflict;

  always_comb begin : addr_decode
    for (int l = 0; l < NLANES; l++) begin
      wa[l]          = eff_addr(a3[5*l +: 5]);
      ra[l]          = eff_addr(a1[5*l +: 5]);
      ra[NLANES + l] = eff_addr(a2[5*l +: 5]);
    end
  end

  // Later lanes override earlier ones, so the highest-numbered matching write wins the bypass.
  always_comb begin : read_mux
    for (int p = 0; p < NPORTS; p++) begin
      rdata[p] = '0;
      if (!reset && ra[p] != 5'd0) begin
        for (int r = 1; r < NREGS; r++) begin
          if (ra[p] == 5'(r)) rdata[p] = regs_q[r];
        end
        for (int l = 0; l < NLANES; l++) begin
          if (we3[l] && wa[l] == ra[p]) rdata[p] = wd3[XLEN*l +: XLEN];
        end
      end
    end
  end

  always_comb begin : read_pack
    rd1 = '0;
    rd2 = '0;
    for (int l = 0; l < NLANES; l++) begin
      rd1[XLEN*l +: XLEN] = rdata[l];
      rd2[XLEN*l +: XLEN] = rdata[NLANES + l];
    end
  end

  always_comb begin : write_merge
    for (int r = 1; r < NREGS; r++) regs_d[r] = regs_q[r];
    for (int l = 0; l < NLANES; l++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (we3[l] && wa[l] == 5'(r)) regs_d[r] = wd3[XLEN*l +: XLEN];
      end
    end
  end

  always_comb begin : conflict_detect
    write_conflict = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      for (int j = i + 1; j < NLANES; j++) begin
        if (we3[i] && we3[j] && wa[i] == wa[j] && wa[i] != 5'd0) write_conflict = 1'b1;
      end
    end
  end

  always_comb begin : count_next
    conflict_count_d = conflict_count_q;
    if (ClearCount) begin
      conflict_count_d = 8'd0;
    end else if (write_conflict && conflict_count_q != 8'hFF) begin
      conflict_count_d = conflict_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NREGS; r++) regs_q[r] <= '0;
      conflict_count_q <= 8'd0;
    end else begin
      for (int r = 1; r < NREGS; r++) regs_q[r] <= regs_d[r];
      conflict_count_q <= conflict_count_d;
    end
  end

  assign WriteConflict = write_conflict;
  assign ConflictCount = conflict_count_q;

endmodule

// File: tb/tb_vliw_regfile.sv
// tb/tb_vliw_regfile.sv - self-checking bench for vliw_regfile
// Drives a full and a reduced (E) register file in parallel against an array-based reference model.
module tb_vliw_regfile;

  logic         clk;
  logic         reset;
  logic [3:0]   we3;
  logic [19:0]  a1, a2, a3;
  logic [255:0] wd3;
  logic         clear_count;
  logic [255:0] rd1_e0, rd2_e0, rd1_e1, rd2_e1;
  logic         wc_e0, wc_e1;
  logic [7:0]   cnt_e0, cnt_e1;

  int n_checks = 0;
  int n_fail   = 0;

  vliw_regfile #(.XLEN(64), .NLANES(4), .E_SUPPORTED(0)) dut_full (
    .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1_e0), .rd2(rd2_e0), .ClearCount(clear_count),
    .WriteConflict(wc_e0), .ConflictCount(cnt_e0)
  );

  vliw_regfile #(.XLEN(64), .NLANES(4), .E_SUPPORTED(1)) dut_e (
    .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1_e1), .rd2(rd2_e1), .ClearCount(clear_count),
    .WriteConflict(wc_e1), .ConflictCount(cnt_e1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural register contents and counters per variant.
  logic [63:0] mem [0:1][0:31];
  int          mcnt [0:1];

  function automatic int ea(int e, int a);
    return (e != 0) ? (a % 16) : a;
  endfunction

  function automatic int lane_a3(int l);
    return int'(a3[5*l +: 5]);
  endfunction

  function automatic logic [63:0] m_read(int e, int addr);
    int a;
    a = ea(e, addr);
    if (reset || a == 0) return 64'd0;
    for (int l = 3; l >= 0; l--) begin
      if (we3[l] && ea(e, lane_a3(l)) == a) return wd3[64*l +: 64];
    end
    return mem[e][a];
  endfunction

  function automatic logic m_conf(int e);
    int hits [32];
    for (int a = 0; a < 32; a++) hits[a] = 0;
    for (int l = 0; l < 4; l++) if (we3[l]) hits[ea(e, lane_a3(l))]++;
    for (int a = 1; a < 32; a++) if (hits[a] > 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int e = 0; e < 2; e++) begin
      for (int a = 0; a < 32; a++) mem[e][a] = 64'd0;
      mcnt[e] = 0;
    end
  endtask

  task automatic m_edge();
    if (reset) return;
    for (int e = 0; e < 2; e++) begin
      if (clear_count) mcnt[e] = 0;
      else if (m_conf(e) && mcnt[e] < 255) mcnt[e] = mcnt[e] + 1;
      for (int l = 0; l < 4; l++) begin
        if (we3[l] && ea(e, lane_a3(l)) != 0) mem[e][ea(e, lane_a3(l))] = wd3[64*l +: 64];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [255:0] r1, r2;
    for (int e = 0; e < 2; e++) begin
      r1 = (e != 0) ? rd1_e1 : rd1_e0;
      r2 = (e != 0) ? rd2_e1 : rd2_e0;
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("%s e%0d rd1[%0d]", tag, e, l), r1[64*l +: 64], m_read(e, int'(a1[5*l +: 5])));
        chk($sformatf("%s e%0d rd2[%0d]", tag, e, l), r2[64*l +: 64], m_read(e, int'(a2[5*l +: 5])));
      end
      chk($sformatf("%s e%0d WriteConflict", tag, e), 64'((e != 0) ? wc_e1 : wc_e0), 64'(m_conf(e)));
      chk($sformatf("%s e%0d ConflictCount", tag, e), 64'((e != 0) ? cnt_e1 : cnt_e0), 64'(mcnt[e]));
    end
  endtask

  function automatic logic [19:0] pk(int x0, int x1, int x2, int x3);
    return {5'(x3), 5'(x2), 5'(x1), 5'(x0)};
  endfunction

  function automatic logic [255:0] pd(logic [63:0] d0, logic [63:0] d1, logic [63:0] d2, logic [63:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic idle();
    we3 = 4'd0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; clear_count = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   we;
    logic [19:0]  ra1, ra2, wa3;
    logic [255:0] wd;
    logic [63:0]  e_rd1_l0;
    logic [63:0]  e_rd2_l3;
    logic         e_wc;
    logic [7:0]   e_cnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{4'b0001, pk(5,0,0,0), pk(0,0,0,5), pk(5,0,0,0), pd(64'h1234,0,0,0), 64'h1234, 64'h1234, 1'b0, 8'd0};
    tbl[1] = '{4'b0000, pk(5,0,0,0), pk(0,0,0,5), pk(0,0,0,0), pd(0,0,0,0), 64'h1234, 64'h1234, 1'b0, 8'd0};
    tbl[2] = '{4'b0110, pk(7,0,0,0), pk(0,0,0,7), pk(0,7,7,0), pd(0,64'hAA,64'hBB,0), 64'hBB, 64'hBB, 1'b1, 8'd0};
    tbl[3] = '{4'b0000, pk(7,0,0,0), pk(0,0,0,5), pk(0,0,0,0), pd(0,0,0,0), 64'hBB, 64'h1234, 1'b0, 8'd1};
    tbl[4] = '{4'b1001, pk(0,0,0,0), pk(0,0,0,0), pk(0,0,0,0), pd(64'hFFFF,0,0,64'hFFFF), 64'h0, 64'h0, 1'b0, 8'd1};
    tbl[5] = '{4'b0000, pk(0,0,0,0), pk(0,0,0,7), pk(0,0,0,0), pd(0,0,0,0), 64'h0, 64'hBB, 1'b0, 8'd1};

    reset = 1'b1;
    idle();
    m_clear();
    we3 = 4'b0011; a3 = pk(4,4,0,0); wd3 = pd(64'h11,64'h22,0,0); a1 = pk(4,4,4,4);
    #2;
    check_all("reset");
    tick();
    reset = 1'b0;
    idle();
    #1;
    check_all("post_reset");

    for (int i = 0; i < 6; i++) begin
      we3 = tbl[i].we; a1 = tbl[i].ra1; a2 = tbl[i].ra2; a3 = tbl[i].wa3; wd3 = tbl[i].wd;
      clear_count = 1'b0;
      #1;
      chk($sformatf("vec%0d rd1[0]", i), rd1_e0[63:0], tbl[i].e_rd1_l0);
      chk($sformatf("vec%0d rd2[3]", i), rd2_e0[255:192], tbl[i].e_rd2_l3);
      chk($sformatf("vec%0d WriteConflict", i), 64'(wc_e0), 64'(tbl[i].e_wc));
      chk($sformatf("vec%0d ConflictCount", i), 64'(cnt_e0), 64'(tbl[i].e_cnt));
      check_all($sformatf("vec%0d", i));
      tick();
    end

    // Saturation, then clear beating a simultaneous increment.
    idle();
    for (int i = 0; i < 260; i++) begin
      we3 = 4'b0011; a3 = pk(3,3,0,0); wd3 = pd(64'(i), 64'(i + 1000), 0, 0); a1 = pk(3,0,0,0);
      #1;
      check_all("sat");
      tick();
    end
    chk("sat count full", 64'(cnt_e0), 64'd255);
    chk("sat count e", 64'(cnt_e1), 64'd255);
    clear_count = 1'b1;
    #1;
    check_all("clear");
    tick();
    idle();
    #1;
    chk("clear priority", 64'(cnt_e0), 64'd0);
    check_all("after_clear");

    // Asynchronous reset pulse between edges.
    we3 = 4'b0001; a3 = pk(9,0,0,0); wd3 = pd(64'h55,0,0,0);
    tick();
    idle();
    we3 = 4'b1100; a3 = pk(0,0,4,4); wd3 = pd(0,0,64'h1,64'h2);
    tick();
    idle();
    a1 = pk(9,0,0,0);
    #1;
    chk("x9 before reset", rd1_e0[63:0], 64'h55);
    chk("count before reset", 64'(cnt_e0), 64'd1);
    reset = 1'b1;
    m_clear();
    we3 = 4'b0011; a3 = pk(9,9,0,0); wd3 = pd(64'hA,64'hB,0,0); a2 = pk(9,9,9,9);
    #1;
    chk("x9 in reset", rd1_e0[63:0], 64'h0);
    chk("count in reset", 64'(cnt_e0), 64'd0);
    chk("conflict in reset", 64'(wc_e0), 64'd1);
    check_all("in_reset");
    tick();
    check_all("reset_edge");
    reset = 1'b0;
    idle();
    a1 = pk(9,9,9,9);
    #1;
    chk("x9 after reset", rd1_e0[63:0], 64'h0);
    check_all("reset_release");
    tick();

    // Address aliasing in the reduced register set.
    idle();
    we3 = 4'b0001; a3 = pk(21,0,0,0); wd3 = pd(64'h77,0,0,0);
    tick();
    idle();
    a1 = pk(5,0,0,0);
    #1;
    chk("alias 21->5", rd1_e1[63:0], 64'h77);
    check_all("alias_read");
    we3 = 4'b0001; a3 = pk(16,0,0,0); wd3 = pd(64'h99,0,0,0); a1 = pk(16,0,0,0);
    #1;
    chk("alias16 bypass e", rd1_e1[63:0], 64'h0);
    check_all("alias16_write");
    tick();
    idle();
    a1 = pk(16,0,0,0);
    #1;
    chk("alias16 dropped e", rd1_e1[63:0], 64'h0);
    chk("x16 stored full", rd1_e0[63:0], 64'h99);
    check_all("alias16_read");

    // Randomized traffic; narrow address window half the time to force collisions.
    for (int i = 0; i < 300; i++) begin
      we3 = 4'($urandom_range(0, 15));
      for (int l = 0; l < 4; l++) begin
        a1[5*l +: 5] = 5'($urandom_range(0, 31));
        a2[5*l +: 5] = 5'($urandom_range(0, 31));
        a3[5*l +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wd3[64*l +: 64] = {$urandom, $urandom};
      end
      clear_count = ($urandom_range(0, 15) == 0);
      #1;
      check_all($sformatf("rand%0d", i));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
